// File: rtl/deserializer.sv
// Word-to-frame deserializer: collects N = OUT_WIDTH/IN_WIDTH accepted words
// into an assembly register and publishes the completed frame on a registered output.
module deserializer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 256,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 output_valid,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (((OUT_WIDTH % IN_WIDTH) != 0) || (N < 2)) begin : g_param_check
    $error("deserializer: OUT_WIDTH must be a multiple of IN_WIDTH with at least 2 words");
  end

  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_asm;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_out_valid;

  logic [CW-1:0]        w_slice;
  logic                 w_last;
  logic [OUT_WIDTH-1:0] w_asm_next;

  assign w_slice = (LSB_FIRST != 0) ? r_cnt : (CW'(N - 1) - r_cnt);
  assign w_last  = (r_cnt == CW'(N - 1));

  // Frame with the current word merged in; on the last word this is what lands on out.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[int'(w_slice) * IN_WIDTH +: IN_WIDTH] = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_asm       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (input_valid) begin
        r_asm <= w_asm_next;
        if (w_last) begin
          r_cnt       <= '0;
          r_out       <= w_asm_next;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign out          = r_out;
  assign output_valid = r_out_valid;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: two instances (LSB-first and MSB-first) share stimulus and
// are compared against a queue-based frame model.
module tb_deserializer;

  localparam int IW = 16;
  localparam int OW = 256;
  localparam int N  = OW / IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          input_valid;
  logic [IW-1:0] din;
  logic          vld_a, vld_b;
  logic [OW-1:0] out_a, out_b;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] q[$];
  logic [OW-1:0] m_out_a, m_out_b;
  logic          m_valid;

  always #5 clk = ~clk;

  deserializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .input_valid(input_valid), .in(din),
    .output_valid(vld_a), .out(out_a));

  deserializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .input_valid(input_valid), .in(din),
    .output_valid(vld_b), .out(out_b));

  // Drive one cycle, then advance the model to what the outputs should show after that edge.
  task automatic step(input logic v, input logic [IW-1:0] d, input logic r);
    input_valid = v;
    din         = d;
    reset       = r;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_out_a = '0;
      m_out_b = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (v) begin
        q.push_back(d);
        if (q.size() == N) begin
          for (int k = 0; k < N; k++) begin
            m_out_a[k*IW +: IW]         = q[k];
            m_out_b[(N-1-k)*IW +: IW]   = q[k];
          end
          m_valid = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_out_a got %h want 0", out_a); end
    checks++; if (out_b !== '0) begin errors++; $display("FAIL reset_out_b got %h want 0", out_b); end
    checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b want 00", vld_a, vld_b); end
  endtask

  task automatic test_single_frame();
    int early = 0;
    for (int i = 1; i <= N; i++) begin
      step(1'b1, IW'(i), 1'b0);
      if (i < N && (vld_a !== 1'b0 || vld_b !== 1'b0)) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL single_early_pulse got %0d want 0", early); end
    checks++; if (vld_a !== 1'b1 || vld_b !== 1'b1) begin errors++; $display("FAIL single_pulse got %b%b want 11", vld_a, vld_b); end
    checks++; if (out_a[15:0] !== 16'h0001 || out_a[255:240] !== 16'h0010) begin
      errors++; $display("FAIL single_lsb_slices got %h/%h want 0001/0010", out_a[15:0], out_a[255:240]); end
    checks++; if (out_b[255:240] !== 16'h0001 || out_b[15:0] !== 16'h0010) begin
      errors++; $display("FAIL single_msb_slices got %h/%h want 0001/0010", out_b[255:240], out_b[15:0]); end
    checks++; if (out_a !== m_out_a || out_b !== m_out_b) begin
      errors++; $display("FAIL single_frame got %h want %h", out_a, m_out_a); end
    step(1'b0, 16'h0000, 1'b0);
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", vld_a); end
  endtask

  task automatic test_gap();
    logic [OW-1:0] expect_frame;
    int n = 0, pulses = 0, pulse_at = -1;
    for (int k = 0; k < N; k++) expect_frame[k*IW +: IW] = IW'(k + 1);
    for (int i = 1; i <= N; i++) begin
      step(1'b1, IW'(i), 1'b0); n++;
      if (vld_a === 1'b1) begin pulses++; pulse_at = n; end
      if (i == 5) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, IW'($urandom), 1'b0); n++;
          if (vld_a === 1'b1) begin pulses++; pulse_at = n; end
        end
      end
    end
    step(1'b0, 16'h0000, 1'b0);
    if (vld_a === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL gap_pulse_count got %0d want 1", pulses); end
    checks++; if (pulse_at != N + 3) begin errors++; $display("FAIL gap_pulse_cycle got %0d want %0d", pulse_at, N + 3); end
    checks++; if (out_a !== expect_frame) begin errors++; $display("FAIL gap_frame got %h want %h", out_a, expect_frame); end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] first;
    int p1 = -1, p2 = -1, held_bad = 0, cmp_bad = 0;
    for (int i = 0; i < 2*N; i++) begin
      step(1'b1, IW'(16'h0100 + i), 1'b0);
      if (out_a !== m_out_a || vld_a !== m_valid || out_b !== m_out_b || vld_b !== m_valid) cmp_bad++;
      if (vld_a === 1'b1) begin
        if (p1 < 0) begin p1 = i + 1; first = out_a; end
        else p2 = i + 1;
      end else if (p1 >= 0 && out_a !== first) held_bad++;
    end
    checks++; if (p1 != N || p2 != 2*N) begin errors++; $display("FAIL b2b_pulses got %0d,%0d want %0d,%0d", p1, p2, N, 2*N); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL b2b_hold got %0d changes want 0", held_bad); end
    checks++; if (out_a[15:0] !== 16'h0110) begin errors++; $display("FAIL b2b_second_word0 got %h want 0110", out_a[15:0]); end
    checks++; if (cmp_bad != 0) begin errors++; $display("FAIL b2b_model got %0d bad cycles want 0", cmp_bad); end
  endtask

  task automatic test_reset_mid();
    int pre = 0, post = 0, post_at = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, IW'($urandom), 1'b0);
      if (vld_a === 1'b1) pre++;
    end
    step(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      step(1'b1, IW'(16'hA000 + i), 1'b0);
      if (vld_a === 1'b1) begin post++; post_at = i + 1; end
    end
    checks++; if (pre != 0) begin errors++; $display("FAIL rstmid_pre_pulse got %0d want 0", pre); end
    checks++; if (post != 1 || post_at != N) begin errors++; $display("FAIL rstmid_pulse got %0d at %0d want 1 at %0d", post, post_at, N); end
    checks++; if (out_a[15:0] !== 16'hA000 || out_a !== m_out_a) begin
      errors++; $display("FAIL rstmid_frame got %h want %h", out_a, m_out_a); end
  endtask

  task automatic test_reset_on_last();
    for (int i = 0; i < N-1; i++) step(1'b1, IW'($urandom), 1'b0);
    step(1'b1, IW'($urandom), 1'b1);
    checks++; if (vld_a !== 1'b0 || out_a !== '0) begin
      errors++; $display("FAIL rstlast_after got vld %b out %h want 0/0", vld_a, out_a); end
    step(1'b0, 16'h0000, 1'b0);
    checks++; if (vld_a !== 1'b0 || out_a !== '0 || vld_b !== 1'b0) begin
      errors++; $display("FAIL rstlast_next got vld %b out %h want 0/0", vld_a, out_a); end
  endtask

  task automatic test_hold();
    logic [OW-1:0] snap;
    int bad = 0;
    for (int i = 0; i < N; i++) step(1'b1, IW'($urandom), 1'b0);
    snap = out_a;
    checks++; if (snap !== m_out_a) begin errors++; $display("FAIL hold_frame got %h want %h", snap, m_out_a); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, IW'($urandom), 1'b0);
      if (out_a !== snap || vld_a !== 1'b0 || vld_b !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_idle got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    int bad = 0, pulses = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 99) == 0);
      if (vld_a === 1'b1) pulses++;
      if (out_a !== m_out_a || out_b !== m_out_b || vld_a !== m_valid || vld_b !== m_valid) begin
        bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d got %b/%h want %b/%h", i, vld_a, out_a, m_valid, m_out_a);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random_total got %0d bad cycles want 0", bad); end
    checks++; if (pulses == 0) begin errors++; $display("FAIL random_pulses got 0 want >0"); end
  endtask

  initial begin
    reset = 1'b1; input_valid = 1'b0; din = '0;
    m_out_a = '0; m_out_b = '0; m_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    test_reset_on_last();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
